mod_tx_controller: RTL

Single-clock frame sequencer that drives the modulator's `valid`/`bit_in` inputs. It accepts a frame request and payload bytes from upstream, serialises an optional preamble and then the payload MSB-first at one bit per symbol period, and closes each frame with a guard gap. It replaces the separate slow clock with an internal symbol counter and a one-cycle `sym_tick` strobe, so the modulator and its feeder share one clock domain.

---
 rtl/mod_tx_controller.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/mod_tx_controller.sv
// Frame sequencer: optional preamble, MSB-first payload with one-byte prefetch, guard gap.
// Define MOD_TX_PREAMBLE_EN to compile in the preamble; otherwise frames start on the first byte.
module mod_tx_controller #(
  parameter int         SYMBOL_CYCLES    = 16,
  parameter logic [7:0] PREAMBLE_PATTERN = 8'hAA,
  parameter int         GAP_SYMBOLS      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] frame_len,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       sym_tick,
  output logic       busy,
  output logic       done,
  output logic       underrun
);
  localparam int SW = (SYMBOL_CYCLES > 1) ? $clog2(SYMBOL_CYCLES) : 1;
  localparam int GW = (GAP_SYMBOLS > 1) ? $clog2(GAP_SYMBOLS) : 1;
  localparam logic [SW-1:0] SYM_LAST = SW'(SYMBOL_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_SYMBOLS - 1);

  typedef enum logic [2:0] {IDLE, FETCH, PREAMBLE, PAYLOAD, GAP} state_t;

  state_t        state_reg, state_next;
  logic [7:0]    len_reg, len_next;
  logic [8:0]    fetch_cnt_reg, fetch_cnt_next;
  logic [8:0]    sent_cnt_reg, sent_cnt_next;
  logic [SW-1:0] sym_cnt_reg, sym_cnt_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [GW-1:0] gap_cnt_reg, gap_cnt_next;
  logic [7:0]    shifter_reg, shifter_next;
  logic [7:0]    buf_reg, buf_next;
  logic          buf_full_reg, buf_full_next;
  logic          bit_out_reg, bit_out_next;
  logic          bit_valid_reg, bit_valid_next;
  logic          sym_tick_reg, sym_tick_next;
  logic          done_reg, done_next;
  logic          underrun_reg, underrun_next;

  logic xfer, sym_end, more_due;

  assign byte_ready = !buf_full_reg && (fetch_cnt_reg < {1'b0, len_reg}) &&
                      (state_reg inside {FETCH, PREAMBLE, PAYLOAD});
  assign xfer     = byte_ready && byte_valid;
  assign sym_end  = (sym_cnt_reg == SYM_LAST);
  assign more_due = (sent_cnt_reg < {1'b0, len_reg});

  always_comb begin
    state_next     = state_reg;
    len_next       = len_reg;
    fetch_cnt_next = fetch_cnt_reg;
    sent_cnt_next  = sent_cnt_reg;
    sym_cnt_next   = sym_cnt_reg;
    bit_idx_next   = bit_idx_reg;
    gap_cnt_next   = gap_cnt_reg;
    shifter_next   = shifter_reg;
    buf_next       = buf_reg;
    buf_full_next  = buf_full_reg;
    bit_out_next   = bit_out_reg;
    bit_valid_next = bit_valid_reg;
    sym_tick_next  = 1'b0;
    done_next      = 1'b0;
    underrun_next  = 1'b0;

    if (xfer) fetch_cnt_next = fetch_cnt_reg + 9'd1;
    if (state_reg inside {PREAMBLE, PAYLOAD, GAP})
      sym_cnt_next = sym_end ? '0 : sym_cnt_reg + 1'b1;

    case (state_reg)
      IDLE: begin
        if (start && frame_len != 8'd0) begin
          len_next       = frame_len;
          fetch_cnt_next = '0;
          sent_cnt_next  = '0;
          sym_cnt_next   = '0;
          bit_idx_next   = 3'd7;
`ifdef MOD_TX_PREAMBLE_EN
          state_next     = PREAMBLE;
          shifter_next   = PREAMBLE_PATTERN;
          bit_out_next   = PREAMBLE_PATTERN[7];
          bit_valid_next = 1'b1;
          sym_tick_next  = 1'b1;
`else
          state_next     = FETCH;
`endif
        end
      end
      FETCH: begin
        // First byte bypasses the buffer straight into the shifter.
        if (xfer) begin
          state_next     = PAYLOAD;
          shifter_next   = byte_data;
          sent_cnt_next  = 9'd1;
          bit_idx_next   = 3'd7;
          sym_cnt_next   = '0;
          bit_out_next   = byte_data[7];
          bit_valid_next = 1'b1;
          sym_tick_next  = 1'b1;
        end
      end
      PREAMBLE, PAYLOAD: begin
        if (sym_end) begin
          if (bit_idx_reg != 3'd0) begin
            bit_idx_next  = bit_idx_reg - 3'd1;
            shifter_next  = {shifter_reg[6:0], 1'b0};
            bit_out_next  = shifter_reg[6];
            sym_tick_next = 1'b1;
          end else if (more_due && buf_full_reg) begin
            state_next     = PAYLOAD;
            shifter_next   = buf_reg;
            buf_full_next  = 1'b0;
            sent_cnt_next  = sent_cnt_reg + 9'd1;
            bit_idx_next   = 3'd7;
            bit_out_next   = buf_reg[7];
            bit_valid_next = 1'b1;
            sym_tick_next  = 1'b1;
          end else if (more_due) begin
            state_next     = IDLE;
            bit_out_next   = 1'b0;
            bit_valid_next = 1'b0;
            underrun_next  = 1'b1;
          end else begin
            state_next     = GAP;
            gap_cnt_next   = '0;
            bit_out_next   = 1'b0;
            bit_valid_next = 1'b0;
            sym_tick_next  = 1'b1;
          end
        end
      end
      GAP: begin
        if (sym_end) begin
          if (gap_cnt_reg == GAP_LAST) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            gap_cnt_next  = gap_cnt_reg + 1'b1;
            sym_tick_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // A fill in the same cycle as a move leaves the buffer full.
    if (xfer && state_reg != FETCH) begin
      buf_next      = byte_data;
      buf_full_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      len_reg       <= '0;
      fetch_cnt_reg <= '0;
      sent_cnt_reg  <= '0;
      sym_cnt_reg   <= '0;
      bit_idx_reg   <= '0;
      gap_cnt_reg   <= '0;
      shifter_reg   <= '0;
      buf_reg       <= '0;
      buf_full_reg  <= 1'b0;
      bit_out_reg   <= 1'b0;
      bit_valid_reg <= 1'b0;
      sym_tick_reg  <= 1'b0;
      done_reg      <= 1'b0;
      underrun_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      len_reg       <= len_next;
      fetch_cnt_reg <= fetch_cnt_next;
      sent_cnt_reg  <= sent_cnt_next;
      sym_cnt_reg   <= sym_cnt_next;
      bit_idx_reg   <= bit_idx_next;
      gap_cnt_reg   <= gap_cnt_next;
      shifter_reg   <= shifter_next;
      buf_reg       <= buf_next;
      buf_full_reg  <= buf_full_next;
      bit_out_reg   <= bit_out_next;
      bit_valid_reg <= bit_valid_next;
      sym_tick_reg  <= sym_tick_next;
      done_reg      <= done_next;
      underrun_reg  <= underrun_next;
    end
  end

  assign bit_out   = bit_out_reg;
  assign bit_valid = bit_valid_reg;
  assign sym_tick  = sym_tick_reg;
  assign done      = done_reg;
  assign underrun  = underrun_reg;
  assign busy      = (state_reg != IDLE);
endmodule
